// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch sequencer.
//   fetch_state_e : sequencer states (fetch, wait for memory, hold for decode, halted)
//   pc_sel_e      : next-PC source selector driven by the FSM into pc_next_sel
//   INSTR_BYTES   : sequential PC increment
//   ALIGN_MASK    : clears the low two bits of redirect targets
package fetch_pkg;

    typedef enum logic [1:0] {
        StFetch,
        StWait,
        StHold,
        StHalt
    } fetch_state_e;

    typedef enum logic [1:0] {
        PcHold,
        PcIncr,
        PcRedirect,
        PcPending
    } pc_sel_e;

    localparam logic [31:0] INSTR_BYTES = 32'd4;
    localparam logic [31:0] ALIGN_MASK  = 32'hFFFF_FFFC;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// fetch_if: bundle of every fetch_control signal except clock and reset.
//   Memory side : imem_req/imem_addr out, imem_ready/imem_rdata in
//   Decode side : instr_valid/instr/instr_pc out, instr_ready in
//   Execute side: redirect_valid/redirect_target in
//   Control     : halt in, pc/halted out
// master = the fetch sequencer, slave = its environment (memory, decode, execute).
interface fetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt;
    logic [31:0] pc;
    logic        halted;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc, pc, halted,
        input  imem_ready, imem_rdata, instr_ready, redirect_valid, redirect_target, halt
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, pc, halted,
        output imem_ready, imem_rdata, instr_ready, redirect_valid, redirect_target, halt
    );

endinterface

// File: rtl/pc_next_sel.sv
// pc_next_sel: combinational next-PC mux.
//   pc_i              : current program counter
//   sel_i             : source select (hold / +INSTR_BYTES / live redirect / pending redirect)
//   redirect_target_i : redirect target from execute this cycle
//   pend_target_i     : redirect target captured earlier while a response was outstanding
//   pc_next_o         : selected next PC; redirect sources are word-aligned here
module pc_next_sel
    import fetch_pkg::*;
(
    input  logic [31:0] pc_i,
    input  pc_sel_e     sel_i,
    input  logic [31:0] redirect_target_i,
    input  logic [31:0] pend_target_i,
    output logic [31:0] pc_next_o
);

    always_comb begin
        pc_next_o = pc_i;
        unique case (sel_i)
            PcHold:     pc_next_o = pc_i;
            // 32-bit add wraps 0xFFFF_FFFC -> 0x0000_0000
            PcIncr:     pc_next_o = pc_i + INSTR_BYTES;
            PcRedirect: pc_next_o = align_pc(redirect_target_i);
            PcPending:  pc_next_o = align_pc(pend_target_i);
            default:    pc_next_o = pc_i;
        endcase
    end

endmodule

// File: rtl/fetch_control.sv
// fetch_control: instruction-fetch sequencer owning the program counter.
//   clk   : system clock, all state on rising edge
//   reset : synchronous active-high reset
//   bus   : fetch_if.master -- memory request/response, decode valid/ready,
//           execute redirect, halt request, pc and halted status
// One memory request is outstanding at most. A redirect seen while waiting on
// memory is parked until the response arrives, then the response is discarded.
module fetch_control
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic     clk,
    input  logic     reset,
    fetch_if.master  bus
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  pc_d;
    logic         pend_q;
    logic [31:0]  pend_target_q;
    logic [31:0]  instr_q;
    logic [31:0]  instr_pc_q;
    pc_sel_e      pc_sel;

    // Next-PC source; redirect from execute always beats everything else.
    always_comb begin
        pc_sel = PcHold;
        unique case (state_q)
            StFetch: begin
                if (bus.redirect_valid) pc_sel = PcRedirect;
            end
            StWait: begin
                if (bus.imem_ready) begin
                    if (bus.redirect_valid) pc_sel = PcRedirect;
                    else if (pend_q)        pc_sel = PcPending;
                end
            end
            StHold: begin
                if (bus.redirect_valid)   pc_sel = PcRedirect;
                else if (bus.instr_ready) pc_sel = PcIncr;
            end
            default: pc_sel = PcHold;
        endcase
    end

    pc_next_sel u_pc_next_sel (
        .pc_i              (pc_q),
        .sel_i             (pc_sel),
        .redirect_target_i (bus.redirect_target),
        .pend_target_i     (pend_target_q),
        .pc_next_o         (pc_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StFetch;
            pc_q          <= RESET_ADDR;
            pend_q        <= 1'b0;
            pend_target_q <= 32'h0;
            instr_q       <= 32'h0;
            instr_pc_q    <= 32'h0;
        end else begin
            pc_q <= pc_d;
            case (state_q)
                StFetch: begin
                    if (!bus.redirect_valid) begin
                        state_q <= bus.halt ? StHalt : StWait;
                    end
                end
                StWait: begin
                    if (bus.imem_ready) begin
                        if (bus.redirect_valid || pend_q) begin
                            // Stale response for the old path: drop it.
                            pend_q  <= 1'b0;
                            state_q <= StFetch;
                        end else begin
                            instr_q    <= bus.imem_rdata;
                            instr_pc_q <= pc_q;
                            state_q    <= StHold;
                        end
                    end else if (bus.redirect_valid) begin
                        pend_q        <= 1'b1;
                        pend_target_q <= bus.redirect_target;
                    end
                end
                StHold: begin
                    if (bus.redirect_valid) begin
                        state_q <= StFetch;
                    end else if (bus.instr_ready) begin
                        state_q <= bus.halt ? StHalt : StFetch;
                    end
                end
                StHalt: state_q <= StHalt;
                default: state_q <= StFetch;
            endcase
        end
    end

    assign bus.imem_req    = (state_q == StFetch) && !bus.halt && !bus.redirect_valid;
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = (state_q == StHold);
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.pc          = pc_q;
    assign bus.halted      = (state_q == StHalt);

endmodule

// File: doc/fetch_control.md
# fetch_control

Instruction-fetch sequencer for the processor front end. Owns the program counter and steps it through a request/response handshake with instruction memory. Hands each fetched word to decode over a valid/ready handshake and applies branch/jump redirects from execute. Sits between the PC register and instruction memory, and replaces a free-running `PC <= nextPC` update with a stall-, redirect- and halt-aware sequence.

## Interface
- RESET_ADDR, 32'h0000_0000, PC value loaded on reset
- INSTR_BYTES, 4, PC increment per sequential instruction
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock; sampled on rising edge of clk
- imem_req  out  1  fetch request to instruction memory, valid for one cycle per fetch
- imem_addr  out  32  fetch address (= pc while imem_req=1)
- imem_ready  in  1  memory response strobe; imem_rdata valid this cycle
- imem_rdata  in  32  fetched instruction word
- instr_valid  out  1  instr/instr_pc hold a valid instruction for decode
- instr_ready  in  1  decode accepts instruction (handshake when valid&ready)
- instr  out  32  instruction word to decode
- instr_pc  out  32  address the instruction was fetched from
- redirect_valid  in  1  execute requests a PC change (taken branch/jump)
- redirect_target  in  32  new PC; bits [1:0] forced to 0 internally
- halt  in  1  stop fetching after current instruction retires to decode
- pc  out  32  current program counter
- halted  out  1  block is in HALT state

## Operation
- States: FETCH, WAIT, HOLD, HALT.
- FETCH: imem_req = !halt && !redirect_valid; imem_addr = pc. If redirect_valid: pc <= target, stay FETCH. Else if halt: go HALT. Else go WAIT.
- WAIT: hold until imem_ready. On imem_ready, if a redirect is pending (flag) or redirect_valid this cycle: discard rdata, pc <= target (current input has priority over pending), clear flag, go FETCH. Else latch instr <= imem_rdata, instr_pc <= pc, go HOLD. redirect_valid without imem_ready: store target in pending register, set flag, stay WAIT (the outstanding response must still be consumed).
- HOLD: instr_valid = 1; instr/instr_pc stable until handshake. If redirect_valid: drop instruction, pc <= target, go FETCH (redirect wins over a same-cycle handshake; the instruction is not counted as accepted). On handshake: pc <= pc + INSTR_BYTES; go HALT if halt, else FETCH.
- HALT: no requests, instr_valid = 0, halted = 1; leaves only by reset.
- pc + INSTR_BYTES wraps modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
- Only one memory request outstanding at any time.

## Timing
- Reset values: pc = RESET_ADDR, state = FETCH, instr = 0, instr_pc = 0, instr_valid = 0, halted = 0, pending flag = 0. imem_req is high in the first cycle after reset deasserts.
- Reset mid-operation: an in-flight response arriving after reset is ignored, because the block is in FETCH, not WAIT.
- Best-case throughput is 1 instruction per 3 cycles: FETCH (req), WAIT (imem_ready), HOLD (instr_ready). The new PC is visible in the next FETCH.
- Each extra cycle of imem_ready latency adds one WAIT cycle. Each cycle instr_ready is low adds one HOLD cycle.
- instr_valid is registered state (HOLD) and is never combinationally dependent on instr_ready.

## Structure
- Shared package fetch_pkg: state enum (FETCH/WAIT/HOLD/HALT), INSTR_BYTES, ALIGN_MASK = 32'hFFFF_FFFC.
- Sub-module pc_next_sel: combinational selection among hold, pc+INSTR_BYTES, current redirect target and pending target, including alignment masking.
- FSM, pc register and pending-redirect register live in fetch_control.

## Test plan
- Reset sequencing: reset for 2 cycles, imem_ready = 1 one cycle after each req, instr_ready = 1 -> imem_addr sequence 0x0, 0x4, 0x8, one instruction every 3 cycles, instr_pc matches.
- Decode stall: instr_ready low for 4 cycles in HOLD -> instr_valid stays 1, instr/instr_pc unchanged, no new imem_req; pc advances by 4 only after the handshake.
- Redirect while waiting: redirect_valid (target 0x100) in WAIT, imem_ready 2 cycles later -> response discarded, instr_valid never rises, next imem_addr = 0x100.
- Redirect vs handshake in HOLD: redirect_valid (0x203) and instr_ready in the same cycle -> instruction dropped, next imem_addr = 0x200.
- Wrap and halt: start pc 0xFFFF_FFFC via redirect, accept one instruction with halt = 1 -> pc = 0x0, halted = 1, no further imem_req until reset.
- Reset mid-WAIT: reset asserted while a request is outstanding, stale imem_ready next cycle -> ignored, imem_addr = RESET_ADDR.
